// File: rtl/sat_gain_pkg.sv
// rtl/sat_gain_pkg.sv - shared types for the saturation gain scheduler
package sat_gain_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DECIDE  = 2'd2
  } state_e;

  localparam int unsigned SHIFT_WIDTH_DEFAULT = 4;

  // Shift amount consumed by the gain shifter ahead of the saturation stage.
  typedef logic [SHIFT_WIDTH_DEFAULT-1:0] shift_t;

endpackage

// File: rtl/sat_gain_ctrl_window_counter.sv
// rtl/sat_gain_ctrl_window_counter.sv - per-window beat and saturation counter
module window_counter #(
  parameter int unsigned WINDOW    = 64,
  parameter int unsigned CNT_WIDTH = $clog2(WINDOW + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 count_en,
  input  logic                 beat_valid,
  input  logic                 beat_sat,
  output logic [CNT_WIDTH-1:0] sat_acc,
  output logic                 done
);

  logic [CNT_WIDTH-1:0] beat_q, beat_d;
  logic [CNT_WIDTH-1:0] sat_q, sat_d;

  // Strobe on the WINDOW-th qualified beat, in the same cycle it is accepted.
  assign done    = count_en && beat_valid && (32'(beat_q) == WINDOW - 1);
  assign sat_acc = sat_q;

  always_comb begin
    beat_d = beat_q;
    sat_d  = sat_q;
    if (clear) begin
      beat_d = '0;
      sat_d  = '0;
    end else if (count_en && beat_valid) begin
      beat_d = beat_q + 1'b1;
      sat_d  = sat_q + CNT_WIDTH'(beat_sat);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_q <= '0;
      sat_q  <= '0;
    end else begin
      beat_q <= beat_d;
      sat_q  <= sat_d;
    end
  end

endmodule

// File: rtl/sat_gain_ctrl.sv
// rtl/sat_gain_ctrl.sv - windowed closed-loop gain shift scheduler
module sat_gain_ctrl
  import sat_gain_pkg::*;
#(
  parameter int unsigned SHIFT_WIDTH = SHIFT_WIDTH_DEFAULT,
  parameter int unsigned SHIFT_INIT  = 4,
  parameter int unsigned SHIFT_MAX   = 15,
  parameter int unsigned WINDOW      = 64,
  parameter int unsigned HI_THRESH   = 4,
  parameter int unsigned LO_THRESH   = 0,
  parameter int unsigned HOLD        = 4,
  parameter int unsigned CNT_WIDTH   = $clog2(WINDOW + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   freeze,
  input  logic                   beat_valid,
  input  logic                   beat_sat,
  output logic [SHIFT_WIDTH-1:0] shift,
  output logic [CNT_WIDTH-1:0]   sat_count,
  output logic                   update
);

  localparam int unsigned HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;

  state_e                 state_q, state_d;
  logic [SHIFT_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_WIDTH-1:0]   sat_count_q, sat_count_d;
  logic                   update_q, update_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;

  logic                   cnt_clear;
  logic                   cnt_en;
  logic [CNT_WIDTH-1:0]   sat_acc;
  logic                   win_done;

  window_counter #(
    .WINDOW   (WINDOW),
    .CNT_WIDTH(CNT_WIDTH)
  ) u_window_counter (
    .clk       (clk),
    .reset     (reset),
    .clear     (cnt_clear),
    .count_en  (cnt_en),
    .beat_valid(beat_valid),
    .beat_sat  (beat_sat),
    .sat_acc   (sat_acc),
    .done      (win_done)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    sat_count_d = sat_count_q;
    update_d    = 1'b0;
    hold_d      = hold_q;
    cnt_clear   = 1'b0;
    cnt_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_clear = 1'b1;
        hold_d    = '0;
        if (enable) state_d = MEASURE;
      end
      MEASURE: begin
        if (!enable) begin
          cnt_clear = 1'b1;
          hold_d    = '0;
          state_d   = IDLE;
        end else begin
          cnt_en = 1'b1;
          if (win_done) state_d = DECIDE;
        end
      end
      DECIDE: begin
        // Decision always completes, even if enable drops in this cycle.
        cnt_clear   = 1'b1;
        update_d    = 1'b1;
        sat_count_d = sat_acc;
        state_d     = enable ? MEASURE : IDLE;
        if (freeze) begin
          hold_d = '0;
        end else if (32'(sat_acc) > HI_THRESH) begin
          shift_d = (shift_q == '0) ? '0 : shift_q - 1'b1;
          hold_d  = '0;
        end else if (32'(sat_acc) <= LO_THRESH) begin
          if (32'(hold_q) == HOLD - 1) begin
            shift_d = (32'(shift_q) >= SHIFT_MAX) ? SHIFT_WIDTH'(SHIFT_MAX) : shift_q + 1'b1;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end else begin
          hold_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= SHIFT_WIDTH'(SHIFT_INIT);
      sat_count_q <= '0;
      update_q    <= 1'b0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      sat_count_q <= sat_count_d;
      update_q    <= update_d;
      hold_q      <= hold_d;
    end
  end

  assign shift     = shift_q;
  assign sat_count = sat_count_q;
  assign update    = update_q;

endmodule

// File: tb/tb_sat_gain_ctrl.sv
// tb/tb_sat_gain_ctrl.sv - directed vector bench for sat_gain_ctrl
module tb_sat_gain_ctrl;

  localparam int SW = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          freeze = 1'b0;
  logic          beat_valid = 1'b0;
  logic          beat_sat = 1'b0;
  logic [SW-1:0] shift;
  logic [CW-1:0] sat_count;
  logic          update;

  sat_gain_ctrl #(
    .SHIFT_WIDTH(SW),
    .SHIFT_INIT (4),
    .SHIFT_MAX  (6),
    .WINDOW     (8),
    .HI_THRESH  (2),
    .LO_THRESH  (0),
    .HOLD       (2),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .freeze    (freeze),
    .beat_valid(beat_valid),
    .beat_sat  (beat_sat),
    .shift     (shift),
    .sat_count (sat_count),
    .update    (update)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst;
    bit frz;
    bit gap;
    int nsat;
    int exp_shift;
    int exp_cnt;
  } vec_t;

  vec_t vecs[22];
  int   n_checks = 0;
  int   n_fail = 0;
  int   upd_seen = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input bit v, input bit s);
    beat_valid = v;
    beat_sat   = s;
    @(posedge clk);
    #1;
    if (update) upd_seen++;
  endtask

  task automatic beats(input int n, input int nsat, input bit gap);
    for (int i = 0; i < n; i++) begin
      if (gap) begin
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
      end
      cyc(1'b1, i < nsat);
    end
  endtask

  initial begin
    vecs[0]  = '{0, 0, 1, 3, 3, 3};
    vecs[1]  = '{0, 0, 0, 3, 2, 3};
    vecs[2]  = '{0, 0, 0, 3, 1, 3};
    vecs[3]  = '{0, 0, 0, 3, 0, 3};
    vecs[4]  = '{0, 0, 0, 3, 0, 3};
    vecs[5]  = '{0, 0, 0, 3, 0, 3};
    vecs[6]  = '{1, 0, 0, 0, 4, 0};
    vecs[7]  = '{0, 0, 0, 0, 5, 0};
    vecs[8]  = '{0, 0, 0, 0, 5, 0};
    vecs[9]  = '{0, 0, 1, 1, 5, 1};
    vecs[10] = '{0, 0, 0, 0, 5, 0};
    vecs[11] = '{0, 0, 0, 2, 5, 2};
    vecs[12] = '{0, 0, 0, 0, 5, 0};
    vecs[13] = '{0, 0, 0, 0, 6, 0};
    vecs[14] = '{0, 0, 0, 0, 6, 0};
    vecs[15] = '{0, 0, 0, 0, 6, 0};
    vecs[16] = '{0, 1, 0, 3, 6, 3};
    vecs[17] = '{0, 0, 0, 8, 5, 8};
    vecs[18] = '{0, 0, 0, 0, 5, 0};
    vecs[19] = '{0, 1, 0, 0, 5, 0};
    vecs[20] = '{0, 0, 0, 0, 5, 0};
    vecs[21] = '{0, 0, 0, 0, 6, 0};

    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    check("reset_shift", int'(shift), 4);
    check("reset_sat_count", int'(sat_count), 0);
    check("reset_update", int'(update), 0);

    reset    = 1'b0;
    upd_seen = 0;
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1);
    check("idle_updates", upd_seen, 0);
    check("idle_shift", int'(shift), 4);
    check("idle_sat_count", int'(sat_count), 0);

    enable = 1'b1;
    cyc(1'b1, 1'b1);

    for (int v = 0; v < 22; v++) begin
      if (vecs[v].rst) begin
        reset = 1'b1;
        cyc(1'b0, 1'b0);
        reset = 1'b0;
        cyc(1'b0, 1'b0);
      end
      freeze   = vecs[v].frz;
      upd_seen = 0;
      beats(8, vecs[v].nsat, vecs[v].gap);
      check($sformatf("v%0d_early_update", v), upd_seen, 0);
      cyc(1'b1, 1'b1);
      freeze = 1'b0;
      check($sformatf("v%0d_update", v), int'(update), 1);
      check($sformatf("v%0d_shift", v), int'(shift), vecs[v].exp_shift);
      check($sformatf("v%0d_sat_count", v), int'(sat_count), vecs[v].exp_cnt);
    end

    cyc(1'b0, 1'b0);
    check("update_one_cycle", int'(update), 0);

    upd_seen = 0;
    beats(5, 3, 1'b0);
    enable = 1'b0;
    cyc(1'b1, 1'b1);
    enable = 1'b1;
    cyc(1'b1, 1'b1);
    beats(7, 0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    check("abort_no_update", upd_seen, 0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    check("abort_update", int'(update), 1);
    check("abort_sat_count", int'(sat_count), 0);
    check("abort_shift", int'(shift), 6);

    beats(8, 3, 1'b0);
    enable = 1'b0;
    cyc(1'b1, 1'b1);
    check("endecide_update", int'(update), 1);
    check("endecide_shift", int'(shift), 5);
    check("endecide_sat_count", int'(sat_count), 3);
    cyc(1'b1, 1'b1);
    check("endecide_update_off", int'(update), 0);

    enable = 1'b1;
    cyc(1'b0, 1'b0);
    upd_seen = 0;
    beats(4, 2, 1'b0);
    reset = 1'b1;
    cyc(1'b1, 1'b1);
    check("midreset_shift", int'(shift), 4);
    check("midreset_sat_count", int'(sat_count), 0);
    check("midreset_update", int'(update), 0);
    reset = 1'b0;
    cyc(1'b1, 1'b1);
    check("midreset_no_update", upd_seen, 0);
    beats(8, 0, 1'b0);
    cyc(1'b0, 1'b0);
    check("postreset_update", int'(update), 1);
    check("postreset_shift", int'(shift), 4);
    check("postreset_sat_count", int'(sat_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sat_gain_ctrl.md
Name: sat_gain_ctrl

Overview:
- Closed-loop gain scheduler for the saturation stage.
- Observes accepted beats on a stream and a per-beat "saturated" flag from the saturation stage, counted over fixed windows of beats.
- At each window end, steps a left-shift gain value that is applied ahead of the saturation stage: less gain when saturation is frequent, more gain after sustained clean windows.
- Sits beside the receive sample path; drives the gain shifter's shift amount and exports per-window statistics.

Parameters:
- SHIFT_WIDTH, 4, width of shift output
- SHIFT_INIT, 4, shift value after reset
- SHIFT_MAX, 15, upper bound of shift; must be < 2**SHIFT_WIDTH
- WINDOW, 64, accepted beats per measurement window; >= 2
- HI_THRESH, 4, window saturation count strictly above this decrements shift
- LO_THRESH, 0, window saturation count at or below this counts as a clean window
- HOLD, 4, consecutive clean windows required before an increment; >= 1
- CNT_WIDTH, $clog2(WINDOW+1), width of sat_count

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- enable  input  1  run measurement; low forces IDLE
- freeze  input  1  evaluate windows but never change shift
- beat_valid  input  1  one stream beat accepted this cycle (valid & ready)
- beat_sat  input  1  accepted beat was saturated; qualified by beat_valid
- shift  output  SHIFT_WIDTH  current gain shift, registered
- sat_count  output  CNT_WIDTH  saturation count of last completed window, registered
- update  output  1  one-cycle pulse: shift/sat_count just refreshed

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset: shift=SHIFT_INIT, sat_count=0, update=0, state IDLE, beat/sat/hold counters 0. Reset mid-window discards the window with no update pulse.
- IDLE:
  - Counters held at 0; shift retained.
  - enable=1 -> MEASURE next cycle; beats during the IDLE cycle are not counted.
- MEASURE:
  - Beat accounting: when beat_valid=1, beat_cnt+1 and sat_acc+beat_sat. beat_sat is ignored when beat_valid=0.
  - Window end: when the WINDOW-th beat is accepted -> DECIDE next cycle.
  - enable=0 in any state except DECIDE -> IDLE next cycle, counters cleared, hold_cnt cleared, no update.
- DECIDE (exactly one cycle):
  - Beats presented in this cycle are discarded.
  - Register updates at the end of this cycle:
    - sat_count <= sat_acc.
    - If freeze: shift unchanged, hold_cnt <= 0.
    - Else if sat_acc > HI_THRESH: shift <= shift-1, floor 0; hold_cnt <= 0.
    - Else if sat_acc <= LO_THRESH: if hold_cnt == HOLD-1, shift <= min(shift+1, SHIFT_MAX) and hold_cnt <= 0; else hold_cnt+1.
    - Else: hold_cnt <= 0.
  - beat_cnt and sat_acc cleared; update <= 1; next state MEASURE.
  - enable=0 during DECIDE: the decision still completes, then IDLE.
- Latency: WINDOW-th beat in cycle t -> DECIDE at t+1 -> new shift/sat_count visible and update=1 at t+2. First countable beat of the next window is at t+2.
- update is high for exactly one cycle per completed window, including when shift is unchanged.
- Width rules:
  - sat_acc is CNT_WIDTH and cannot overflow (at most WINDOW).
  - shift never leaves [0, SHIFT_MAX].
  - Threshold comparisons are unsigned.

Decomposition:
- Package sat_gain_pkg: state enum (IDLE, MEASURE, DECIDE); shared typedef for shift values used by the shifter.
- One sub-module, window_counter: counts qualified beats and saturations, issues a done strobe on the WINDOW-th beat. The FSM and gain-step logic stay in the top module.

Test Plan:
- Bench parameters: WINDOW=8, HI_THRESH=2, LO_THRESH=0, HOLD=2, SHIFT_INIT=4, SHIFT_MAX=6.
- Reset, then idle with enable=0 and 20 beats -> shift=4, sat_count=0, update never asserts.
- enable=1; 8 beats, 3 with beat_sat=1 -> update pulses 2 cycles after the 8th beat, sat_count=3, shift=3; 5 more such windows -> shift 2,1,0,0,0.
- Clean windows from shift=4 -> window 1: shift 4; window 2: shift 5; window 4: shift 6; window 6: shift stays 6; a 1-sat window (between LO and HI) resets hold, so 2 more clean windows are needed before the next step.
- beat_valid gapped (1 in 3 cycles), with beat_sat=1 on idle cycles -> those saturations not counted; window closes on the 8th valid beat; sat_count equals qualified sats only; beat on the DECIDE cycle not counted.
- Abort, freeze and reset:
  - Drop enable after 5 beats -> no update; re-enable -> 8 fresh beats needed.
  - freeze=1 with a 3-sat window -> update pulses, sat_count=3, shift unchanged.
  - Assert reset mid-window -> shift=4, no update.
